// File: rtl/uart_controller_mc.sv
// rtl/uart_controller_mc.sv - UART NIC front end with RX/TX ring FIFOs, interrupts and loopback
// Serial framing: 1 start bit, WORD_SIZE data bits LSB first, 1 stop bit.

module uart_receiver #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_read,
  output logic                 avbl
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(WORD_SIZE + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t            state;
  logic [1:0]           rx_s;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_idx;
  logic [WORD_SIZE-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s      <= 2'b11;
      state     <= R_IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_read <= '0;
      avbl      <= 1'b0;
    end else begin
      rx_s <= {rx_s[0], rx};
      avbl <= 1'b0;
      case (state)
        R_IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          if (!rx_s[1]) state <= R_START;
        end
        // Wait half a bit so later samples land mid-bit; reject glitches.
        R_START: begin
          if (baud == CW'(CLKS_PER_BIT / 2 - 1)) begin
            baud  <= '0;
            state <= rx_s[1] ? R_IDLE : R_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        R_DATA: begin
          if (baud == CW'(CLKS_PER_BIT - 1)) begin
            baud    <= '0;
            shreg   <= {rx_s[1], shreg[WORD_SIZE-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(WORD_SIZE - 1)) state <= R_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          if (baud == CW'(CLKS_PER_BIT - 1)) begin
            baud  <= '0;
            state <= R_IDLE;
            if (rx_s[1]) begin
              data_read <= shreg;
              avbl      <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module uart_transmitter #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [WORD_SIZE-1:0] data,
  output logic                 tx,
  output logic                 avbl
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(WORD_SIZE + 2);

  logic                 busy;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_idx;
  logic [WORD_SIZE+1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (!busy) begin
      if (send) begin
        shreg   <= {1'b1, data, 1'b0};
        busy    <= 1'b1;
        baud    <= '0;
        bit_idx <= '0;
      end
    end else if (baud == CW'(CLKS_PER_BIT - 1)) begin
      baud  <= '0;
      shreg <= {1'b1, shreg[WORD_SIZE+1:1]};
      if (bit_idx == BW'(WORD_SIZE + 1)) busy <= 1'b0;
      else bit_idx <= bit_idx + 1'b1;
    end else begin
      baud <= baud + 1'b1;
    end
  end

  assign tx   = busy ? shreg[0] : 1'b1;
  assign avbl = !busy;
endmodule

module uart_controller_mc #(
  parameter int WORD_SIZE     = 8,
  parameter int RX_DEPTH      = 8,
  parameter int TX_DEPTH      = 8,
  parameter int RX_OVERWRITE  = 1,
  parameter int RX_IRQ_THRESH = 4,
  parameter int TX_IRQ_THRESH = 2,
  parameter int IDLE_TIMEOUT  = 64,
  parameter int CLKS_PER_BIT  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  output logic                            tx,
  input  logic [WORD_SIZE-1:0]            data_in,
  input  logic                            write_nic,
  input  logic                            read_nic,
  input  logic                            loopback,
  input  logic                            clr_err,
  output logic [WORD_SIZE-1:0]            data_out,
  output logic                            data_out_valid,
  output logic                            read_nic_i,
  output logic                            tx_space_i,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_count,
  output logic                            tx_full,
  output logic                            rx_overflow,
  output logic                            tx_overflow,
  output logic                            rx_underflow
);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int IW    = $clog2(IDLE_TIMEOUT + 1);
  localparam bit OVW   = (RX_OVERWRITE != 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_BUSY} tx_state_t;

  logic                 rx_in, tx_int, rx_avbl, tx_avbl, tx_send;
  logic [WORD_SIZE-1:0] data_read, tx_data;

  assign rx_in = loopback ? tx_int : rx;
  assign tx    = loopback ? 1'b1 : tx_int;

  uart_receiver #(.WORD_SIZE(WORD_SIZE), .CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rx(rx_in), .data_read(data_read), .avbl(rx_avbl)
  );

  uart_transmitter #(.WORD_SIZE(WORD_SIZE), .CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst(rst), .send(tx_send), .data(tx_data), .tx(tx_int), .avbl(tx_avbl)
  );

  logic [WORD_SIZE-1:0] rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]     rx_wr, rx_rd;
  logic                 rx_full, rx_pop, rx_acc, rx_wr_en, rx_ovw;

  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_pop   = read_nic && (rx_count != '0);
  assign rx_acc   = rx_avbl && (!rx_full || rx_pop);
  assign rx_ovw   = rx_avbl && rx_full && !rx_pop && OVW;
  assign rx_wr_en = rx_acc || rx_ovw;

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr] <= data_read;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr          <= '0;
      rx_rd          <= '0;
      rx_count       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      rx_overflow    <= 1'b0;
      rx_underflow   <= 1'b0;
    end else begin
      data_out_valid <= rx_pop;
      if (rx_pop) data_out <= rx_mem[rx_rd];
      if (rx_wr_en) rx_wr <= (rx_wr == RX_PW'(RX_DEPTH - 1)) ? '0 : rx_wr + 1'b1;
      // Overwrite drops the oldest entry by sliding the read pointer past it.
      if (rx_pop || rx_ovw) rx_rd <= (rx_rd == RX_PW'(RX_DEPTH - 1)) ? '0 : rx_rd + 1'b1;
      if (rx_acc && !rx_pop) rx_count <= rx_count + 1'b1;
      else if (!rx_acc && rx_pop) rx_count <= rx_count - 1'b1;
      if (clr_err) begin
        rx_overflow  <= 1'b0;
        rx_underflow <= 1'b0;
      end
      if (rx_avbl && rx_full && !rx_pop) rx_overflow <= 1'b1;
      if (read_nic && rx_count == '0) rx_underflow <= 1'b1;
    end
  end

  logic [WORD_SIZE-1:0] tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]     tx_wr, tx_rd;
  logic                 tx_pop, tx_acc;
  tx_state_t            tx_state;
  logic                 wait_cnt;

  assign tx_full = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_pop  = (tx_state == S_IDLE) && (tx_count != '0) && tx_avbl;
  assign tx_acc  = write_nic && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_acc) tx_mem[tx_wr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr       <= '0;
      tx_rd       <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_acc) tx_wr <= (tx_wr == TX_PW'(TX_DEPTH - 1)) ? '0 : tx_wr + 1'b1;
      if (tx_pop) tx_rd <= (tx_rd == TX_PW'(TX_DEPTH - 1)) ? '0 : tx_rd + 1'b1;
      if (tx_acc && !tx_pop) tx_count <= tx_count + 1'b1;
      else if (!tx_acc && tx_pop) tx_count <= tx_count - 1'b1;
      if (clr_err) tx_overflow <= 1'b0;
      if (write_nic && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  // One word in flight: WAIT covers the transmitter's latency in dropping avbl.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_data  <= '0;
      tx_send  <= 1'b0;
      wait_cnt <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_data  <= tx_mem[tx_rd];
            tx_send  <= 1'b1;
            tx_state <= S_SEND;
          end
        end
        S_SEND: begin
          tx_send  <= 1'b0;
          wait_cnt <= 1'b0;
          tx_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_avbl || wait_cnt) tx_state <= S_BUSY;
          else wait_cnt <= 1'b1;
        end
        default: begin
          if (tx_avbl) tx_state <= S_IDLE;
        end
      endcase
    end
  end

  logic [IW-1:0] idle_cnt;
  logic          idle_flag;

  assign idle_flag = (idle_cnt == IW'(IDLE_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt   <= '0;
      read_nic_i <= 1'b0;
      tx_space_i <= 1'b0;
    end else begin
      if (rx_avbl || read_nic || rx_count == '0) idle_cnt <= '0;
      else if (!idle_flag) idle_cnt <= idle_cnt + 1'b1;
      read_nic_i <= (rx_count >= RX_CW'(RX_IRQ_THRESH)) || idle_flag;
      tx_space_i <= (tx_count <= TX_CW'(TX_IRQ_THRESH));
    end
  end
endmodule

// File: tb/tb_uart_controller_mc.sv
// tb/tb_uart_controller_mc.sv - directed bench for uart_controller_mc
// dut0 uses the overwrite policy, dut1 drops newest; both share all inputs.

module tb_uart_controller_mc;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       write_nic = 1'b0, read_nic = 1'b0, loopback = 1'b0, clr_err = 1'b0;

  logic       tx0, tx1;
  logic [7:0] data_out0, data_out1;
  logic       valid0, valid1, rirq0, rirq1, tirq0, tirq1;
  logic [3:0] rx_count0, rx_count1, tx_count0, tx_count1;
  logic       tx_full0, tx_full1, rx_ovf0, rx_ovf1, tx_ovf0, tx_ovf1, rx_unf0, rx_unf1;

  int total = 0;
  int mism = 0;
  logic [7:0] mon_q[$];

  always #5 clk = ~clk;

  uart_controller_mc #(.RX_OVERWRITE(1), .CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .rst(rst), .rx(rx_line), .tx(tx0), .data_in(data_in),
    .write_nic(write_nic), .read_nic(read_nic), .loopback(loopback), .clr_err(clr_err),
    .data_out(data_out0), .data_out_valid(valid0), .read_nic_i(rirq0), .tx_space_i(tirq0),
    .rx_count(rx_count0), .tx_count(tx_count0), .tx_full(tx_full0),
    .rx_overflow(rx_ovf0), .tx_overflow(tx_ovf0), .rx_underflow(rx_unf0)
  );

  uart_controller_mc #(.RX_OVERWRITE(0), .CLKS_PER_BIT(CPB)) dut1 (
    .clk(clk), .rst(rst), .rx(rx_line), .tx(tx1), .data_in(data_in),
    .write_nic(write_nic), .read_nic(read_nic), .loopback(loopback), .clr_err(clr_err),
    .data_out(data_out1), .data_out_valid(valid1), .read_nic_i(rirq1), .tx_space_i(tirq1),
    .rx_count(rx_count1), .tx_count(tx_count1), .tx_full(tx_full1),
    .rx_overflow(rx_ovf1), .tx_overflow(tx_ovf1), .rx_underflow(rx_unf1)
  );

  // Decodes frames on dut0's external tx pin, sampling mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx0 === 1'b0) begin
        repeat (2) @(negedge clk);
        if (tx0 === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx0;
          end
          repeat (CPB) @(negedge clk);
          mon_q.push_back(b);
        end
      end
    end
  end

  task send_frame(input logic [7:0] b);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task pulse_read;
    read_nic = 1'b1;
    @(negedge clk);
    read_nic = 1'b0;
  endtask

  task pulse_write(input logic [7:0] d);
    write_nic = 1'b1;
    data_in = d;
    @(negedge clk);
    write_nic = 1'b0;
  endtask

  task pulse_clr;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_count0 !== 4'd0 || tx_count0 !== 4'd0 || tx_full0 !== 1'b0) begin mism++; $display("FAIL reset_counts rx=%0d tx=%0d full=%b want 0 0 0", rx_count0, tx_count0, tx_full0); end
    total++; if (data_out0 !== 8'h00 || valid0 !== 1'b0) begin mism++; $display("FAIL reset_data data=%h valid=%b want 00 0", data_out0, valid0); end
    total++; if (rirq0 !== 1'b0 || tirq0 !== 1'b0) begin mism++; $display("FAIL reset_irq r=%b t=%b want 0 0", rirq0, tirq0); end
    total++; if ({rx_ovf0, tx_ovf0, rx_unf0} !== 3'b000 || tx0 !== 1'b1) begin mism++; $display("FAIL reset_flags flags=%b tx=%b want 000 1", {rx_ovf0, tx_ovf0, rx_unf0}, tx0); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (tirq0 !== 1'b1) begin mism++; $display("FAIL reset_tx_space got %b want 1", tirq0); end
  endtask

  task test_loopback;
    logic [7:0] exp [3];
    int n;
    logic tx_bad;
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
    loopback = 1'b1;
    @(negedge clk);
    tx_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_write(exp[i]);
      if (tx0 !== 1'b1) tx_bad = 1'b1;
    end
    n = 0;
    while (rx_count0 !== 4'd3 && n < 800) begin
      @(negedge clk);
      if (tx0 !== 1'b1) tx_bad = 1'b1;
      n++;
    end
    total++; if (rx_count0 !== 4'd3) begin mism++; $display("FAIL lb_rx_count got %0d want 3", rx_count0); end
    total++; if (tx_bad !== 1'b0) begin mism++; $display("FAIL lb_tx_idle got toggling want 1"); end
    for (int i = 0; i < 3; i++) begin
      pulse_read;
      total++; if (valid0 !== 1'b1 || data_out0 !== exp[i]) begin mism++; $display("FAIL lb_read%0d data=%h valid=%b want %h 1", i, data_out0, valid0, exp[i]); end
    end
    @(negedge clk);
    total++; if (valid0 !== 1'b0) begin mism++; $display("FAIL lb_valid_pulse got %b want 0", valid0); end
    loopback = 1'b0;
    @(negedge clk);
  endtask

  task test_rx_overflow;
    for (int i = 1; i <= 10; i++) send_frame(8'(i));
    repeat (4) @(negedge clk);
    total++; if (rx_count0 !== 4'd8 || rx_count1 !== 4'd8) begin mism++; $display("FAIL ovf_count got %0d/%0d want 8/8", rx_count0, rx_count1); end
    total++; if (rx_ovf0 !== 1'b1 || rx_ovf1 !== 1'b1) begin mism++; $display("FAIL ovf_flag got %b/%b want 1/1", rx_ovf0, rx_ovf1); end
    for (int i = 0; i < 8; i++) begin
      pulse_read;
      total++; if (data_out0 !== 8'(i + 3)) begin mism++; $display("FAIL ovf_overwrite%0d got %h want %h", i, data_out0, 8'(i + 3)); end
      total++; if (data_out1 !== 8'(i + 1)) begin mism++; $display("FAIL ovf_drop%0d got %h want %h", i, data_out1, 8'(i + 1)); end
    end
    pulse_clr;
    total++; if (rx_ovf0 !== 1'b0 || rx_ovf1 !== 1'b0) begin mism++; $display("FAIL ovf_clear got %b/%b want 0/0", rx_ovf0, rx_ovf1); end
  endtask

  task test_tx_full;
    int n;
    mon_q.delete();
    pulse_write(8'h11);
    repeat (6) @(negedge clk);
    write_nic = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'h20 + 8'(i);
      @(negedge clk);
    end
    write_nic = 1'b0;
    total++; if (tx_count0 !== 4'd8 || tx_full0 !== 1'b1) begin mism++; $display("FAIL txf_count cnt=%0d full=%b want 8 1", tx_count0, tx_full0); end
    total++; if (tx_ovf0 !== 1'b1) begin mism++; $display("FAIL txf_overflow got %b want 1", tx_ovf0); end
    total++; if (tirq0 !== 1'b0) begin mism++; $display("FAIL txf_space_low got %b want 0", tirq0); end
    pulse_clr;
    total++; if (tx_ovf0 !== 1'b0) begin mism++; $display("FAIL txf_clear got %b want 0", tx_ovf0); end
    n = 0;
    while (tx_count0 !== 4'd2 && n < 800) begin @(negedge clk); n++; end
    @(negedge clk);
    total++; if (tx_count0 !== 4'd2 || tirq0 !== 1'b1) begin mism++; $display("FAIL txf_space cnt=%0d irq=%b want 2 1", tx_count0, tirq0); end
    n = 0;
    while (mon_q.size() < 9 && n < 800) begin @(negedge clk); n++; end
    repeat (150) @(negedge clk);
    total++; if (mon_q.size() !== 9) begin mism++; $display("FAIL txf_frames got %0d want 9", mon_q.size()); end
    if (mon_q.size() > 0) begin
      total++; if (mon_q[0] !== 8'h11) begin mism++; $display("FAIL txf_word0 got %h want 11", mon_q[0]); end
    end
    for (int i = 1; i < 9 && i < mon_q.size(); i++) begin
      total++; if (mon_q[i] !== 8'h1F + 8'(i)) begin mism++; $display("FAIL txf_word%0d got %h want %h", i, mon_q[i], 8'h1F + 8'(i)); end
    end
  endtask

  task test_simultaneous;
    int n;
    for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i));
    repeat (4) @(negedge clk);
    fork send_frame(8'h48); join_none
    n = 0;
    while (dut0.rx_avbl !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (dut0.rx_avbl !== 1'b1) begin mism++; $display("FAIL sim_push_timeout got no push want push"); end
    pulse_read;
    total++; if (rx_count0 !== 4'd8 || rx_count1 !== 4'd8) begin mism++; $display("FAIL sim_count got %0d/%0d want 8/8", rx_count0, rx_count1); end
    total++; if (rx_ovf0 !== 1'b0 || rx_ovf1 !== 1'b0) begin mism++; $display("FAIL sim_no_ovf got %b/%b want 0/0", rx_ovf0, rx_ovf1); end
    total++; if (data_out0 !== 8'h40 || valid0 !== 1'b1) begin mism++; $display("FAIL sim_head data=%h valid=%b want 40 1", data_out0, valid0); end
    wait fork;
    for (int i = 0; i < 8; i++) begin
      pulse_read;
      total++; if (data_out0 !== 8'h41 + 8'(i)) begin mism++; $display("FAIL sim_drain%0d got %h want %h", i, data_out0, 8'h41 + 8'(i)); end
    end
    pulse_read;
    total++; if (rx_unf0 !== 1'b1 || valid0 !== 1'b0) begin mism++; $display("FAIL sim_underflow unf=%b valid=%b want 1 0", rx_unf0, valid0); end
    total++; if (data_out0 !== 8'h48) begin mism++; $display("FAIL sim_hold got %h want 48", data_out0); end
    pulse_clr;
  endtask

  task test_interrupts;
    int n;
    fork send_frame(8'h77); join_none
    n = 0;
    while (dut0.rx_avbl !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      if (rirq0 === 1'b1 || n >= 200) break;
      n++;
    end
    total++; if (n !== 65) begin mism++; $display("FAIL irq_idle_delay got %0d want 65", n); end
    wait fork;
    pulse_read;
    total++; if (data_out0 !== 8'h77) begin mism++; $display("FAIL irq_idle_word got %h want 77", data_out0); end
    repeat (4) @(negedge clk);
    total++; if (rirq0 !== 1'b0) begin mism++; $display("FAIL irq_clear got %b want 0", rirq0); end
    for (int i = 0; i < 3; i++) send_frame(8'h80 + 8'(i));
    repeat (4) @(negedge clk);
    fork send_frame(8'h83); join_none
    n = 0;
    while (dut0.rx_avbl !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    total++; if (rirq0 !== 1'b0 || rx_count0 !== 4'd4) begin mism++; $display("FAIL irq_thresh_pre irq=%b cnt=%0d want 0 4", rirq0, rx_count0); end
    @(negedge clk);
    total++; if (rirq0 !== 1'b1) begin mism++; $display("FAIL irq_thresh got %b want 1", rirq0); end
    wait fork;
    for (int i = 0; i < 4; i++) pulse_read;
    total++; if (data_out0 !== 8'h83) begin mism++; $display("FAIL irq_last_word got %h want 83", data_out0); end
  endtask

  task test_reset_midframe;
    int n;
    for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i));
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) pulse_write(8'h60 + 8'(i));
    repeat (3) @(negedge clk);
    total++; if (rx_count0 !== 4'd3 || tx_count0 !== 4'd5) begin mism++; $display("FAIL rst_setup rx=%0d tx=%0d want 3 5", rx_count0, tx_count0); end
    fork send_frame(8'h99); join_none
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (rx_count0 !== 4'd0 || tx_count0 !== 4'd0 || tx_full0 !== 1'b0) begin mism++; $display("FAIL rst_counts rx=%0d tx=%0d full=%b want 0 0 0", rx_count0, tx_count0, tx_full0); end
    total++; if (data_out0 !== 8'h00 || valid0 !== 1'b0 || rirq0 !== 1'b0 || tirq0 !== 1'b0) begin mism++; $display("FAIL rst_outputs data=%h v=%b r=%b t=%b want 00 0 0 0", data_out0, valid0, rirq0, tirq0); end
    total++; if ({rx_ovf0, tx_ovf0, rx_unf0} !== 3'b000 || tx0 !== 1'b1) begin mism++; $display("FAIL rst_flags flags=%b tx=%b want 000 1", {rx_ovf0, tx_ovf0, rx_unf0}, tx0); end
    wait fork;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    loopback = 1'b1;
    @(negedge clk);
    pulse_write(8'h5A);
    n = 0;
    while (rx_count0 !== 4'd1 && n < 300) begin @(negedge clk); n++; end
    total++; if (rx_count0 !== 4'd1) begin mism++; $display("FAIL rst_lb_count got %0d want 1", rx_count0); end
    pulse_read;
    total++; if (data_out0 !== 8'h5A || valid0 !== 1'b1) begin mism++; $display("FAIL rst_lb_word data=%h valid=%b want 5a 1", data_out0, valid0); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_rx_overflow;
    test_tx_full;
    test_simultaneous;
    test_interrupts;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, mism);
    $finish;
  end
endmodule
